// File: rtl/wb_dmem_bridge_pkg.sv
// Shared types for the data-memory Wishbone bridge:
// request bundle, FSM state encoding and the default timeout read word.
package wb_dmem_bridge_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] mtrans_t;

  typedef struct packed {
    addr_t      a;
    logic       we;
    logic [3:0] be;
    mtrans_t    d;
  } dmem_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam mtrans_t DMEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_dmem_bridge_if.sv
// Decoupled request/response channels between the load/store unit and the
// bridge. master = load/store side, slave = bridge side.
interface wb_dmem_bridge_if;
  import wb_dmem_bridge_pkg::*;

  logic      req_valid;
  logic      req_ready;
  dmem_req_t req;

  logic      resp_valid;
  logic      resp_ready;
  mtrans_t   resp_data;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/wb_dmem_bridge_watchdog.sv
// wb_watchdog: counts cycles while en_i is high, clears when low.
// Ports: clk, rst, en_i, expired_o. Only built with DMEM_TIMEOUT_EN.
`ifdef DMEM_TIMEOUT_EN
module wb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW =
    ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // Leaving BUS zeroes the count, so every BUS entry starts fresh.
  always_comb begin
    cnt_d = en_i ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires during the LIMIT-th BUS cycle so cyc is high exactly LIMIT cycles.
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/wb_dmem_bridge.sv
// wb_dmem_bridge: one Wishbone classic cycle per load/store request.
// Ports: clk, rst, mem (decoupled req/resp), wb_* bus, bus_err (DMEM_TIMEOUT_EN).
module wb_dmem_bridge
  import wb_dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter mtrans_t     ERR_DATA       = DMEM_ERR_DATA
)
(
  input  logic                   clk,
  input  logic                   rst,
  wb_dmem_bridge_if.slave        mem,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [31:0]            wb_adr_o,
  output logic [3:0]             wb_sel_o,
  output logic [31:0]            wb_dat_o,
  input  logic [31:0]            wb_dat_i,
`ifdef DMEM_TIMEOUT_EN
  output logic                   bus_err,
`endif
  input  logic                   wb_ack_i
);

  dmem_state_t state_q, state_d;
  dmem_req_t   req_q, req_d;
  mtrans_t     resp_q, resp_d;
  logic        in_bus;

  assign in_bus = (state_q == BUS);

`ifdef DMEM_TIMEOUT_EN
  logic err_q, err_d;
  logic wdt_exp;

  wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .en_i      (in_bus),
    .expired_o (wdt_exp)
  );

  assign bus_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
`ifdef DMEM_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem.req_valid) begin
          req_d   = mem.req;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack wins over a same-cycle timeout.
        if (wb_ack_i) begin
          resp_d  = req_q.we ? '0 : wb_dat_i;
          state_d = RESP;
`ifdef DMEM_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wdt_exp) begin
          resp_d  = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        if (mem.resp_ready) begin
          state_d = IDLE;
`ifdef DMEM_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      resp_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
`ifdef DMEM_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Bus outputs come only from registers; zero outside BUS.
  assign wb_cyc_o = in_bus;
  assign wb_stb_o = in_bus;
  assign wb_we_o  = in_bus && req_q.we;
  assign wb_adr_o = in_bus ? {req_q.a[31:2], 2'b00} : '0;
  assign wb_sel_o = in_bus ? req_q.be : '0;
  assign wb_dat_o = in_bus ? req_q.d : '0;

  assign mem.req_ready  = (state_q == IDLE);
  assign mem.resp_valid = (state_q == RESP);
  assign mem.resp_data  = resp_q;

endmodule
